rename_reg_file: RTL
====================

# rename_reg_file

Parametrised architectural register file with rename-tag tracking, serving the dispatch stage and the reservation stations of the out-of-order core. It holds committed register values plus a per-register busy bit and ROB tag naming the in-flight producer. It answers `NRD` operand lookups per cycle and, one cycle after each commit, broadcasts the committed value to waiting consumers. An explicit busy bit replaces the "tag 0 means ready" encoding, so every ROB tag, including 0, is usable.

## Interface
- `XLEN`, 32: data width.
- `NREG`, 32: architectural register count (power of two, ≥2); `RW = $clog2(NREG)`.
- `TAG_W`, 5: ROB tag width.
- `NRD`, 2: operand lookup ports.

Ports:
- `clk_in` in 1: clock; all state changes on the rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global enable; low freezes all state and outputs.
- `clear` in 1: pipeline flush.
- `launch_valid` in 1, `launch_rd` in RW, `launch_tag` in TAG_W: rename `launch_rd` to `launch_tag`.
- `commit_valid` in 1, `commit_rd` in RW, `commit_tag` in TAG_W, `commit_value` in XLEN: retire a result.
- `ask_rd` in NRD*RW: lookup indices, port k at bits [k*RW +: RW].
- `dep_busy` out NRD: port k register awaits a producer.
- `dep_tag` out NRD*TAG_W: producer tag. Meaningful only when busy.
- `dep_value` out NRD*XLEN: register value.
- `msg_valid` out 1, `msg_tag` out TAG_W, `msg_value` out XLEN: registered commit broadcast.

## Operation
- State per register r: `value[r]`, `busy[r]`, `tag[r]`. Register 0 is never busy and always reads value 0. Launches and commits to r=0 never modify register 0.
- Reset: all `value`, `busy` and `tag` entries are 0. `msg_valid`, `msg_tag` and `msg_value` are 0.
- `rdy_in` = 0: no state update. Broadcast outputs hold their values. Read ports stay combinational on the frozen state.
- Commit with `commit_rd` ≠ 0:
  - `value[commit_rd]` ← `commit_value`.
  - `busy[commit_rd]` ← 0 only if busy and `tag[commit_rd]` == `commit_tag`. Otherwise a younger producer owns the register and busy/tag are kept.
- Launch with `launch_rd` ≠ 0: `busy` ← 1, `tag` ← `launch_tag`.
- Launch and commit to the same register in the same cycle: the launch wins busy/tag, and the value is still written.
- `clear` = 1:
  - All `busy` and `tag` entries ← 0.
  - Launch is ignored.
  - The commit value write still happens, because committed state is architectural.
  - `msg_valid` ← 0.
- Broadcast: `msg_valid` ← `commit_valid` && `commit_rd` ≠ 0 && !`clear`. `msg_tag` and `msg_value` are loaded from the commit inputs whenever a broadcast is issued, and are held otherwise.
- Read ports are combinational on current state. For `ask_rd` = 0 they return busy 0, tag 0 and value 0.

## Timing
- A launch at edge N is visible on `dep_busy`/`dep_tag` during cycle N+1.
- A commit at edge N updates `dep_value` and `dep_busy` during cycle N+1. `msg_valid` pulses for exactly one cycle, N+1, per commit.
- Back-to-back commits produce back-to-back single-cycle broadcasts.
- A lookup in the same cycle as a launch to that register still sees the pre-launch state. Dispatch owns intra-bundle renaming.
- No internal pipelining beyond the broadcast register. Throughput is one launch and one commit per cycle.

## Configuration
- `RF_COMMIT_BYPASS_EN` defined: when a lookup port asks for a register that matches all of the following in the same cycle:
  - `commit_valid` is high,
  - `ask_rd` == `commit_rd` ≠ 0,
  - `busy` is 1,
  - `tag` == `commit_tag`,
  
  then the port outputs `dep_busy` = 0 and `dep_value` = `commit_value` combinationally. This closes the commit-to-dispatch gap.
- Undefined: reads reflect only registered state. The bypass logic is not built.

## Test plan
- Reset, then read x5 and x0 on both ports -> busy 0, tag 0, value 0. `msg_valid` 0.
- Launch x5 with tag 0, then commit x5 with tag 0 and value 0xDEADBEEF -> cycle after launch: busy=1, tag=0. Cycle after commit: busy=0, value 0xDEADBEEF, `msg_valid`=1, `msg_tag`=0 for one cycle.
- Launch x7 with tag 3, then launch x7 with tag 9, then commit x7 with tag 3 and value 0x11 -> value 0x11, busy stays 1 with tag 9. Same-cycle launch x8 tag 4 plus commit x8 tag 2 (x8 busy with tag 2) -> busy 1, tag 4, value written.
- Launch and commit to x0, and launch x1 while `rdy_in`=0 -> x0 stays busy 0 / value 0. No broadcast for the x0 commit. x1 unchanged until `rdy_in` returns.
- Make x3 and x4 busy, then assert `clear` together with a commit of x3 value 0x55 -> all busy 0, x3 value 0x55, `msg_valid` 0 next cycle.
- With `RF_COMMIT_BYPASS_EN`: x6 busy with tag 12, and commit x6 tag 12 value 0x1234 while port 1 asks for x6 -> same cycle: `dep_busy[1]`=0, value 0x1234. Without the macro: busy 1 that cycle, resolved in the next cycle.

Source files
------------

// File: rtl/rename_reg_file_if.sv
// Dispatch/retire bus of the rename register file: rename launch, commit,
// operand lookup ports and the registered commit broadcast.
interface rename_reg_file_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 5,
    parameter int NRD   = 2
);
    localparam int RW = $clog2(NREG);

    logic                 launch_valid;
    logic [RW-1:0]        launch_rd;
    logic [TAG_W-1:0]     launch_tag;

    logic                 commit_valid;
    logic [RW-1:0]        commit_rd;
    logic [TAG_W-1:0]     commit_tag;
    logic [XLEN-1:0]      commit_value;

    logic [NRD*RW-1:0]    ask_rd;
    logic [NRD-1:0]       dep_busy;
    logic [NRD*TAG_W-1:0] dep_tag;
    logic [NRD*XLEN-1:0]  dep_value;

    logic                 msg_valid;
    logic [TAG_W-1:0]     msg_tag;
    logic [XLEN-1:0]      msg_value;

    modport master (
        output launch_valid, launch_rd, launch_tag,
        output commit_valid, commit_rd, commit_tag, commit_value,
        output ask_rd,
        input  dep_busy, dep_tag, dep_value,
        input  msg_valid, msg_tag, msg_value
    );

    modport slave (
        input  launch_valid, launch_rd, launch_tag,
        input  commit_valid, commit_rd, commit_tag, commit_value,
        input  ask_rd,
        output dep_busy, dep_tag, dep_value,
        output msg_valid, msg_tag, msg_value
    );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register busy bit and producer ROB tag.
// Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle resolving commit to lookups.
module rename_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 5,
    parameter int NRD   = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    rename_reg_file_if.slave  bus
);
    localparam int RW = $clog2(NREG);

    logic [XLEN-1:0]  value_q [NREG];
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [NREG-1:0]  busy_q;

    logic msg_fire;
    assign msg_fire = bus.commit_valid && (bus.commit_rd != '0) && !clear;

    // Register 0 is skipped so it stays at its reset contents forever.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            for (int r = 1; r < NREG; r++) begin
                if (bus.commit_valid && bus.commit_rd == RW'(r))
                    value_q[r] <= bus.commit_value;

                if (clear) begin
                    busy_q[r] <= 1'b0;
                    tag_q[r]  <= '0;
                end else if (bus.launch_valid && bus.launch_rd == RW'(r)) begin
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= bus.launch_tag;
                end else if (bus.commit_valid && bus.commit_rd == RW'(r) &&
                             busy_q[r] && tag_q[r] == bus.commit_tag) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // Broadcast stage: tag/value only reload on an issued broadcast.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.msg_valid <= 1'b0;
            bus.msg_tag   <= '0;
            bus.msg_value <= '0;
        end else if (rdy_in) begin
            bus.msg_valid <= msg_fire;
            if (msg_fire) begin
                bus.msg_tag   <= bus.commit_tag;
                bus.msg_value <= bus.commit_value;
            end
        end
    end

    always_comb begin
        logic [RW-1:0] rd;
        bus.dep_busy  = '0;
        bus.dep_tag   = '0;
        bus.dep_value = '0;
        for (int k = 0; k < NRD; k++) begin
            rd = bus.ask_rd[k*RW +: RW];
            if (rd != '0) begin
                bus.dep_busy[k]                = busy_q[rd];
                bus.dep_tag[k*TAG_W +: TAG_W]  = tag_q[rd];
                bus.dep_value[k*XLEN +: XLEN]  = value_q[rd];
`ifdef RF_COMMIT_BYPASS_EN
                if (bus.commit_valid && bus.commit_rd == rd &&
                    busy_q[rd] && tag_q[rd] == bus.commit_tag) begin
                    bus.dep_busy[k]               = 1'b0;
                    bus.dep_value[k*XLEN +: XLEN] = bus.commit_value;
                end
`endif
            end
        end
    end
endmodule
